// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port word memory between three read ports and one
//   write port. One access is granted per cycle in round-robin order
//   (readers 0..2, writer = 3). The granted command is registered onto the
//   mem_* bus, and read data is steered back to its issuer by an in-order
//   tag pipeline that matches the memory read latency.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   rd_req/rd_addr/rd_gnt      read requests (3), packed word addresses, grant pulses
//   rd_dvalid/rd_data          per-reader return strobe, shared return bus
//   wr_req/wr_addr/wr_data/wr_strb/wr_gnt   write request channel and grant pulse
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_strb  registered memory command
//   mem_rdata                  memory read data, RD_LAT cycles after mem_ren
//   busy                       command on the bus or read in flight
module mem_port_arbiter #(
  parameter int unsigned AXI_WIDTH      = 128,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AW             = AXI_ADDR_WIDTH - $clog2(AXI_WIDTH/8),
  parameter int unsigned RD_LAT         = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [2:0]             rd_req,
  input  logic [3*AW-1:0]        rd_addr,
  output logic [2:0]             rd_gnt,
  output logic [2:0]             rd_dvalid,
  output logic [AXI_WIDTH-1:0]   rd_data,
  input  logic                   wr_req,
  input  logic [AW-1:0]          wr_addr,
  input  logic [AXI_WIDTH-1:0]   wr_data,
  input  logic [AXI_WIDTH/8-1:0] wr_strb,
  output logic                   wr_gnt,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [AXI_WIDTH-1:0]   mem_wdata,
  output logic [AXI_WIDTH/8-1:0] mem_strb,
  input  logic [AXI_WIDTH-1:0]   mem_rdata,
  output logic                   busy
);

  logic [1:0]             r_ptr;
  logic                   r_ren;
  logic                   r_wen;
  logic [AW-1:0]          r_addr;
  logic [AXI_WIDTH-1:0]   r_wdata;
  logic [AXI_WIDTH/8-1:0] r_strb;
  logic [1:0]             r_tag;
  logic [RD_LAT-1:0]      r_pv;
  logic [1:0]             r_pt [RD_LAT];

  logic [3:0]             w_req;
  logic [1:0]             w_idx;
  logic [1:0]             w_win;
  logic                   w_found;
  logic [3:0]             w_gnt;
  logic [AW-1:0]          w_rd_addr;
  logic [2:0]             w_dv;

  assign w_req = {wr_req, rd_req};

  // Scan from the priority pointer; 2-bit index arithmetic wraps mod 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (rstn && w_found) w_gnt[w_win] = 1'b1;
  end

  assign rd_gnt = w_gnt[2:0];
  assign wr_gnt = w_gnt[3];

  always_comb begin
    case (w_win)
      2'd0:    w_rd_addr = rd_addr[AW-1:0];
      2'd1:    w_rd_addr = rd_addr[2*AW-1:AW];
      default: w_rd_addr = rd_addr[3*AW-1:2*AW];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_tag   <= '0;
    end else if (w_found) begin
      r_ptr <= w_win + 2'd1;
      if (w_win == 2'd3) begin
        r_ren   <= 1'b0;
        r_wen   <= 1'b1;
        r_addr  <= wr_addr;
        r_wdata <= wr_data;
        r_strb  <= wr_strb;
      end else begin
        r_ren  <= 1'b1;
        r_wen  <= 1'b0;
        r_addr <= w_rd_addr;
        r_tag  <= w_win;
      end
    end else begin
      r_ren <= 1'b0;
      r_wen <= 1'b0;
    end
  end

  // Tag pipeline: stage 0 loads while mem_ren is on the bus, so the last
  // stage lines up with mem_rdata RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pv <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_pt[i] <= '0;
    end else begin
      r_pv[0] <= r_ren;
      r_pt[0] <= r_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  always_comb begin
    w_dv = '0;
    for (int unsigned i = 0; i < 3; i++)
      w_dv[i] = r_pv[RD_LAT-1] && (r_pt[RD_LAT-1] == 2'(i));
  end

  assign rd_dvalid = w_dv;
  assign rd_data   = mem_rdata;
  assign mem_ren   = r_ren;
  assign mem_wen   = r_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_strb  = r_strb;
  assign busy      = r_ren | r_wen | (|r_pv);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: one instance with RD_LAT=1 backed
//   by a small byte-enabled memory model, one with RD_LAT=3 fed a constant
//   read word for return-timing checks.
module tb_mem_port_arbiter;

  localparam int unsigned W  = 128;
  localparam int unsigned AW = 28;
  localparam logic [W-1:0] PAT  = 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010;
  localparam logic [W-1:0] RD3K = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // RD_LAT=1 instance
  logic [2:0]      rd_req;
  logic [3*AW-1:0] rd_addr;
  logic [2:0]      rd_gnt, rd_dvalid;
  logic [W-1:0]    rd_data;
  logic            wr_req, wr_gnt;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic [W/8-1:0]  wr_strb;
  logic            mem_ren, mem_wen, busy;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    mem_wdata, mem_rdata;
  logic [W/8-1:0]  mem_strb;

  // RD_LAT=3 instance
  logic [2:0]      rd_req3;
  logic [3*AW-1:0] rd_addr3;
  logic [2:0]      rd_gnt3, rd_dvalid3;
  logic [W-1:0]    rd_data3;
  logic            wr_gnt3, mem_ren3, mem_wen3, busy3;
  logic [AW-1:0]   mem_addr3;
  logic [W-1:0]    mem_wdata3;
  logic [W/8-1:0]  mem_strb3;
  logic [W-1:0]    mem_rdata3;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_dvalid(rd_dvalid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_gnt(wr_gnt),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_gnt(rd_gnt3),
    .rd_dvalid(rd_dvalid3), .rd_data(rd_data3),
    .wr_req(1'b0), .wr_addr('0), .wr_data('0), .wr_strb('0),
    .wr_gnt(wr_gnt3),
    .mem_ren(mem_ren3), .mem_wen(mem_wen3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_strb(mem_strb3), .mem_rdata(mem_rdata3),
    .busy(busy3)
  );

  // Memory model: all zeros except word 0x10, loaded on the first edge.
  logic [W-1:0] mem_arr [64] = '{default: '0};
  logic         preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      mem_arr[16]  <= PAT;
      preload_done <= 1'b1;
    end
    if (mem_wen)
      for (int b = 0; b < W/8; b++)
        if (mem_strb[b]) mem_arr[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_ren) mem_rdata <= mem_arr[mem_addr[5:0]];
  end

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task smp;
    @(negedge clk);
  endtask

  task test_reset;
    rstn = 1'b0; rd_req = 3'b111; wr_req = 1'b1; rd_req3 = 3'b111;
    cyc; cyc; smp;
    vectors++; if (rd_gnt !== 3'b000) begin miscompares++; $display("FAIL rst_rd_gnt got=%b exp=000", rd_gnt); end
    vectors++; if (wr_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_wr_gnt got=%b exp=0", wr_gnt); end
    vectors++; if (rd_gnt3 !== 3'b000) begin miscompares++; $display("FAIL rst_rd_gnt3 got=%b exp=000", rd_gnt3); end
    vectors++; if ({mem_ren, mem_wen} !== 2'b00) begin miscompares++; $display("FAIL rst_en got=%b exp=00", {mem_ren, mem_wen}); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
    vectors++; if (mem_strb !== '0) begin miscompares++; $display("FAIL rst_strb got=%h exp=0", mem_strb); end
    vectors++; if (rd_dvalid !== 3'b000) begin miscompares++; $display("FAIL rst_dvalid got=%b exp=000", rd_dvalid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    cyc;
    rd_req = '0; wr_req = 1'b0; rd_req3 = '0; rstn = 1'b1;
    cyc;
  endtask

  task test_single_read;
    rd_req = 3'b010; rd_addr = {28'h0, 28'h10, 28'h0};
    smp;
    vectors++; if (rd_gnt !== 3'b010) begin miscompares++; $display("FAIL sr_gnt got=%b exp=010", rd_gnt); end
    vectors++; if (wr_gnt !== 1'b0) begin miscompares++; $display("FAIL sr_wgnt got=%b exp=0", wr_gnt); end
    cyc; rd_req = '0; smp;
    vectors++; if ({mem_ren, mem_wen} !== 2'b10) begin miscompares++; $display("FAIL sr_en got=%b exp=10", {mem_ren, mem_wen}); end
    vectors++; if (mem_addr !== 28'h10) begin miscompares++; $display("FAIL sr_addr got=%h exp=10", mem_addr); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sr_busy got=%b exp=1", busy); end
    vectors++; if (rd_dvalid !== 3'b000) begin miscompares++; $display("FAIL sr_early_dv got=%b exp=000", rd_dvalid); end
    cyc; smp;
    vectors++; if (rd_dvalid !== 3'b010) begin miscompares++; $display("FAIL sr_dvalid got=%b exp=010", rd_dvalid); end
    vectors++; if (rd_data !== PAT) begin miscompares++; $display("FAIL sr_data got=%h exp=%h", rd_data, PAT); end
    cyc; smp;
    vectors++; if (rd_dvalid !== 3'b000) begin miscompares++; $display("FAIL sr_dv_once got=%b exp=000", rd_dvalid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sr_idle got=%b exp=0", busy); end
    cyc;
  endtask

  task automatic test_round_robin;
    int unsigned e, p;
    logic [2:0] exp_rd;
    rstn = 1'b0; cyc; rstn = 1'b1;
    rd_req = 3'b111; wr_req = 1'b1;
    rd_addr = {28'h32, 28'h31, 28'h30};
    wr_addr = 28'h3F; wr_data = {8{16'h5A5A}}; wr_strb = '1;
    for (int k = 0; k < 8; k++) begin
      smp;
      e = k % 4;
      exp_rd = (e < 3) ? 3'(1 << e) : 3'b000;
      vectors++; if (rd_gnt !== exp_rd) begin miscompares++; $display("FAIL rr_rd_gnt k=%0d got=%b exp=%b", k, rd_gnt, exp_rd); end
      vectors++; if (wr_gnt !== (e == 3)) begin miscompares++; $display("FAIL rr_wr_gnt k=%0d got=%b exp=%b", k, wr_gnt, (e == 3)); end
      if (k > 0) begin
        p = (k - 1) % 4;
        vectors++; if ({mem_ren, mem_wen} !== ((p < 3) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_en k=%0d got=%b exp_prev_idx=%0d", k, {mem_ren, mem_wen}, p); end
        vectors++; if (mem_addr !== ((p < 3) ? 28'(28'h30 + p) : 28'h3F)) begin miscompares++; $display("FAIL rr_addr k=%0d got=%h exp_prev_idx=%0d", k, mem_addr, p); end
      end
      cyc;
    end
    rd_req = '0; wr_req = 1'b0;
    cyc; cyc; cyc;
  endtask

  task test_write_read;
    wr_req = 1'b1; wr_addr = 28'h20; wr_data = {16{8'hA5}}; wr_strb = '1;
    smp;
    vectors++; if ({wr_gnt, rd_gnt} !== 4'b1000) begin miscompares++; $display("FAIL wr_gnt got=%b exp=1000", {wr_gnt, rd_gnt}); end
    cyc; wr_req = 1'b0; rd_req = 3'b100; rd_addr = {28'h20, 28'h0, 28'h0}; smp;
    vectors++; if ({mem_ren, mem_wen} !== 2'b01) begin miscompares++; $display("FAIL wr_en got=%b exp=01", {mem_ren, mem_wen}); end
    vectors++; if (mem_addr !== 28'h20) begin miscompares++; $display("FAIL wr_addr got=%h exp=20", mem_addr); end
    vectors++; if (mem_wdata !== {16{8'hA5}}) begin miscompares++; $display("FAIL wr_wdata got=%h", mem_wdata); end
    vectors++; if (mem_strb !== 16'hFFFF) begin miscompares++; $display("FAIL wr_strb got=%h exp=ffff", mem_strb); end
    vectors++; if (rd_gnt !== 3'b100) begin miscompares++; $display("FAIL wr_rgnt got=%b exp=100", rd_gnt); end
    cyc; rd_req = '0; smp;
    vectors++; if ({mem_ren, mem_wen} !== 2'b10) begin miscompares++; $display("FAIL wr_ren got=%b exp=10", {mem_ren, mem_wen}); end
    cyc; smp;
    vectors++; if (rd_dvalid !== 3'b100) begin miscompares++; $display("FAIL wr_dvalid got=%b exp=100", rd_dvalid); end
    vectors++; if (rd_data !== {16{8'hA5}}) begin miscompares++; $display("FAIL wr_rdata got=%h exp=a5..a5", rd_data); end
    cyc;
  endtask

  task test_partial_strobe;
    wr_req = 1'b1; wr_addr = 28'h08; wr_data = {{14{8'h11}}, 16'hBEEF}; wr_strb = 16'h0003;
    smp;
    vectors++; if (wr_gnt !== 1'b1) begin miscompares++; $display("FAIL ps_gnt got=%b exp=1", wr_gnt); end
    cyc; wr_addr = 28'h09; wr_data = '1; wr_strb = '0; smp;
    vectors++; if (mem_strb !== 16'h0003) begin miscompares++; $display("FAIL ps_strb got=%h exp=0003", mem_strb); end
    vectors++; if (wr_gnt !== 1'b1) begin miscompares++; $display("FAIL ps_zero_gnt got=%b exp=1", wr_gnt); end
    cyc; wr_req = 1'b0; rd_req = 3'b001; rd_addr = {28'h0, 28'h0, 28'h08}; smp;
    vectors++; if ({mem_wen, mem_strb, mem_addr} !== {1'b1, 16'h0000, 28'h09}) begin miscompares++; $display("FAIL ps_zero_issue got=%b/%h/%h exp=1/0000/9", mem_wen, mem_strb, mem_addr); end
    vectors++; if (rd_gnt !== 3'b001) begin miscompares++; $display("FAIL ps_rgnt got=%b exp=001", rd_gnt); end
    cyc; rd_req = '0; cyc; smp;
    vectors++; if (rd_dvalid !== 3'b001) begin miscompares++; $display("FAIL ps_dvalid got=%b exp=001", rd_dvalid); end
    vectors++; if (rd_data !== 128'h0000BEEF) begin miscompares++; $display("FAIL ps_data got=%h exp=0000beef", rd_data); end
    cyc;
  endtask

  task test_back_to_back_lat3;
    rd_req3 = 3'b101; rd_addr3 = {28'h2, 28'h0, 28'h1}; mem_rdata3 = RD3K;
    smp;
    vectors++; if (rd_gnt3 !== 3'b001) begin miscompares++; $display("FAIL l3_gnt0 got=%b exp=001", rd_gnt3); end
    cyc; smp;
    vectors++; if (rd_gnt3 !== 3'b100) begin miscompares++; $display("FAIL l3_gnt1 got=%b exp=100", rd_gnt3); end
    cyc; smp;
    vectors++; if (rd_gnt3 !== 3'b001) begin miscompares++; $display("FAIL l3_gnt2 got=%b exp=001", rd_gnt3); end
    cyc; rd_req3 = '0; smp;
    vectors++; if (rd_dvalid3 !== 3'b000) begin miscompares++; $display("FAIL l3_early got=%b exp=000", rd_dvalid3); end
    vectors++; if (busy3 !== 1'b1) begin miscompares++; $display("FAIL l3_busy got=%b exp=1", busy3); end
    cyc; smp;
    vectors++; if (rd_dvalid3 !== 3'b001) begin miscompares++; $display("FAIL l3_dv0 got=%b exp=001", rd_dvalid3); end
    vectors++; if (rd_data3 !== RD3K) begin miscompares++; $display("FAIL l3_data got=%h exp=%h", rd_data3, RD3K); end
    cyc; smp;
    vectors++; if (rd_dvalid3 !== 3'b100) begin miscompares++; $display("FAIL l3_dv1 got=%b exp=100", rd_dvalid3); end
    cyc; smp;
    vectors++; if (rd_dvalid3 !== 3'b001) begin miscompares++; $display("FAIL l3_dv2 got=%b exp=001", rd_dvalid3); end
    cyc; smp;
    vectors++; if (rd_dvalid3 !== 3'b000) begin miscompares++; $display("FAIL l3_dv_end got=%b exp=000", rd_dvalid3); end
    vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL l3_idle got=%b exp=0", busy3); end
    cyc;
  endtask

  task test_reset_midflight;
    rd_req = 3'b010; rd_addr = {28'h0, 28'h10, 28'h0};
    smp;
    vectors++; if (rd_gnt !== 3'b010) begin miscompares++; $display("FAIL mf_gnt got=%b exp=010", rd_gnt); end
    cyc; rd_req = '0; rstn = 1'b0; smp;
    vectors++; if (mem_ren !== 1'b1) begin miscompares++; $display("FAIL mf_issued got=%b exp=1", mem_ren); end
    cyc; rstn = 1'b1; smp;
    vectors++; if ({mem_ren, mem_wen, busy} !== 3'b000) begin miscompares++; $display("FAIL mf_en_busy got=%b exp=000", {mem_ren, mem_wen, busy}); end
    vectors++; if (rd_dvalid !== 3'b000) begin miscompares++; $display("FAIL mf_dvalid got=%b exp=000", rd_dvalid); end
    vectors++; if ({mem_addr, mem_wdata, mem_strb} !== '0) begin miscompares++; $display("FAIL mf_cmd got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_strb); end
    cyc; rd_req = 3'b110; rd_addr = {28'h11, 28'h10, 28'h0}; smp;
    vectors++; if (rd_dvalid !== 3'b000) begin miscompares++; $display("FAIL mf_dvalid_late got=%b exp=000", rd_dvalid); end
    vectors++; if (rd_gnt !== 3'b010) begin miscompares++; $display("FAIL mf_ptr0 got=%b exp=010", rd_gnt); end
    cyc; rd_req = '0;
    cyc; cyc;
  endtask

  initial begin
    rstn = 1'b0; rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0;
    wr_data = '0; wr_strb = '0; rd_req3 = '0; rd_addr3 = '0; mem_rdata3 = '0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_write_read;
    test_partial_strobe;
    test_back_to_back_lat3;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port word memory between the three MM2S read ports (mm2s_0/1/2) and the S2MM write port of top_ram.
- Grants at most one memory access per cycle using round-robin arbitration, registers the memory command, and routes returned read data back to the issuing requester via an in-order tag pipeline.
- Sits between the DMA engines and the memory model or BRAM, in place of their separate direct ports.

Parameters:
- AXI_WIDTH, 128, memory word width in bits (multiple of 8).
- AXI_ADDR_WIDTH, 32, byte address width.
- AW, AXI_ADDR_WIDTH-$clog2(AXI_WIDTH/8), word address width.
- RD_LAT, 1, memory read latency in cycles from registered mem_ren to valid mem_rdata (>=1).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- rd_req  in  3  read request per reader; held until granted
- rd_addr  in  3*AW  word addresses; reader i at [i*AW +: AW]; stable while rd_req[i]=1
- rd_gnt  out  3  one-cycle grant pulse per reader (combinational)
- rd_dvalid  out  3  read data valid for reader i
- rd_data  out  AXI_WIDTH  shared read-return bus; qualify with rd_dvalid
- wr_req  in  1  write request; held until granted
- wr_addr  in  AW  write word address
- wr_data  in  AXI_WIDTH  write data
- wr_strb  in  AXI_WIDTH/8  byte enables
- wr_gnt  out  1  one-cycle write grant pulse (combinational)
- mem_ren  out  1  registered memory read enable
- mem_wen  out  1  registered memory write enable
- mem_addr  out  AW  registered memory word address
- mem_wdata  out  AXI_WIDTH  registered write data
- mem_strb  out  AXI_WIDTH/8  registered byte enables
- mem_rdata  in  AXI_WIDTH  memory read data, RD_LAT cycles after mem_ren
- busy  out  1  high while any read is in flight or any mem_ren/mem_wen is asserted

Behaviour:
- Requester indices: 0,1,2 = readers; 3 = writer.
- ptr (2b) holds the highest-priority index; reset value 0.
- Cycle t:
  - winner = first index with request set, scanning ptr, ptr+1, ... mod 4.
  - The winner's gnt is asserted combinationally in cycle t; at most one gnt bit is set per cycle.
  - If a winner exists, ptr <= winner+1 mod 4; otherwise ptr holds.
- Cycle t+1: mem_* outputs carry the granted command.
  - mem_ren=1 for a read; mem_wen=1 for a write; never both.
  - When no command is issued, mem_ren=mem_wen=0 and addr/wdata/strb hold their previous values.
- A write with wr_strb=0 is still granted and issued, with mem_strb=0.
- Read return:
  - A 2b tag plus valid bit travels in a shift register of depth RD_LAT alongside mem_ren.
  - Cycle t+1+RD_LAT: rd_dvalid[tag]=1 for exactly one cycle; rd_data=mem_rdata (combinational pass-through).
  - Returns are strictly in issue order; there is no backpressure on the return path.
- Throughput and fairness:
  - Up to 1 access per cycle, back-to-back.
  - A continuously requesting port is granted within 4 cycles.
- Requesters may deassert or re-raise rd_req/wr_req the cycle after gnt. Re-raising in that cycle counts as a new request.
- Ordering: accesses reach memory in grant order, so a read granted after a write to the same address returns the new data. No address hazard logic is needed.
- Reset (rstn=0 at posedge), including mid-operation:
  - rd_gnt=0, wr_gnt=0 (gated by rstn).
  - mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_strb=0.
  - rd_dvalid=0, busy=0, ptr=0, all in-flight tags cleared; reads issued before reset never produce rd_dvalid.

Test Plan:
- Single read, RD_LAT=1: reader 1 requests addr 0x10 at cycle 5 → rd_gnt=3'b010 at cycle 5; mem_ren=1, mem_addr=0x10 at 6; rd_dvalid=3'b010 with rd_data=mem_rdata at 7.
- All four request continuously from cycle 10, ptr=0 → grant order 0,1,2,W,0,1,... one per cycle; each port granted every 4th cycle; mem_ren/mem_wen never both high.
- Write then read, same address: W writes 0xA5 bytes to addr 0x20 with strb all ones, then reader 2 reads 0x20 → returned data all 0xA5.
- Partial strobe: wr_strb=16'h0003, data 0xBEEF into a word of zeros → read returns 0x...0000BEEF.
- RD_LAT=3, reads from readers 0,2,0 back-to-back → rd_dvalid pulses 001,100,001 on three consecutive cycles, each 4 cycles after its grant.
- Reset mid-flight: rstn=0 the cycle after a read grant → no rd_dvalid afterwards; all outputs 0; ptr=0; the first request after release wins by index from 0.
